// File: rtl/alu_seq_if.sv
// Operand request / result response bundle for alu_seq; the master is the requester and consumer side.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             neg;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, carry, ovf, neg, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf, neg, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: logic/arith ops in 1 cycle, multiply by WIDTH-cycle shift-add (WIDTH+1 latency).
// Result and flags held until out_ready; in_ready low while multiplying or holding a result.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave io
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic [WIDTH-1:0] acc_next;
    logic             accept;

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.busy      = (state == MUL);
    assign io.result    = result_q;
    assign io.carry     = carry_q;
    assign io.ovf       = ovf_q;
    assign io.zero      = (result_q == '0);
    assign io.neg       = result_q[WIDTH-1];

    assign accept = io.in_valid && io.in_ready;

    // The extra top bit gives add carry-out and, for subtract, the unsigned borrow.
    assign sum  = {1'b0, io.a} + {1'b0, io.b};
    assign diff = {1'b0, io.a} - {1'b0, io.b};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (io.op)
            3'b000: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (io.a[WIDTH-1] == io.b[WIDTH-1]) && (sum[WIDTH-1] != io.a[WIDTH-1]);
            end
            3'b001: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (io.a[WIDTH-1] != io.b[WIDTH-1]) && (diff[WIDTH-1] != io.a[WIDTH-1]);
            end
            3'b010:  alu_res = io.a & io.b;
            3'b011:  alu_res = io.a | io.b;
            3'b100:  alu_res = ~io.b;
            3'b101:  alu_res = io.a ^ io.b;
            3'b110:  alu_res = io.a << io.b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (io.op == 3'b111) begin
                            mcand  <= io.a;
                            mplier <= io.b;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            result_q <= alu_res;
                            carry_q  <= alu_carry;
                            ovf_q    <= alu_ovf;
                            state    <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    // Last iteration publishes the product directly from the adder.
                    if (cnt == LAST) begin
                        result_q <= acc_next;
                        carry_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's combinational 32-bit ALU. Accepts one operation at a time over a valid/ready input port, executes single-cycle logic/arithmetic ops in one clock, executes multiply as a WIDTH-cycle shift-add sequence, and holds a registered result plus status flags until the consumer takes it. It sits between the operand/decode stage and the writeback/register-file stage.

## Interface
- WIDTH, 32, operand/result width; legal values are powers of two, 4 to 64.
- SHW, $clog2(WIDTH), derived shift-amount width; do not override.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the a/b/op inputs hold a request.
- in_ready  out  1  the block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  the consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- carry  out  1  add carry-out / sub borrow; 0 for other ops.
- ovf  out  1  signed overflow for add/sub; 0 for other ops.
- neg  out  1  result[WIDTH-1].
- busy  out  1  a multiply is in progress (state MUL).

## Operation
- Op codes: 000 a+b; 001 a-b; 010 a&b; 011 a|b; 100 ~b; 101 a^b; 110 a << b[SHW-1:0] (logical, zero-fill); 111 a*b, keeping the low WIDTH bits (unsigned).
- Add: carry = bit WIDTH of the (WIDTH+1)-bit sum. Sub: carry = 1 if a < b unsigned (borrow).
- ovf on add: the operands have the same sign and the result sign differs. ovf on sub: the operands have different signs and the result sign differs from a.
- FSM states:
  - IDLE: in_ready = !out_valid.
  - MUL: in_ready = 0, busy = 1.
  - DONE: out_valid = 1, in_ready = 0.
- Accept happens when in_valid && in_ready.
- IDLE + accept of op != 111: result and flags are computed combinationally from a, b and op, registered, and the FSM goes to DONE.
- IDLE + accept of op 111: a is latched into the multiplicand register, b into the multiplier register, the accumulator is cleared, the counter is set to 0, and the FSM goes to MUL.
- MUL, each cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand (mod 2^WIDTH).
  - Multiplicand <<= 1, multiplier >>= 1, counter++.
  - When counter == WIDTH-1 on this cycle, the final value is written to result, flags are computed (carry = ovf = 0), and the FSM goes to DONE.
- DONE: the output is held stable until out_ready = 1; that edge clears out_valid and the FSM goes to IDLE.
- No input is accepted in the cycle the output is taken (one bubble per op); throughput is at most one op per 2 cycles.
- in_valid while busy: ignored; the requester must hold the request until in_ready.
- Undefined op bits cannot occur: all 8 codes are defined.

## Timing
- Reset, synchronous, takes priority over everything:
  - State = IDLE; out_valid = 0, busy = 0.
  - result = 0, zero = 1, carry = 0, ovf = 0, neg = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset asserted mid-multiply or while DONE: the operation and any held result are discarded, with no output.
- Latency, measured from the accept edge to the edge at which out_valid rises:
  - single-cycle ops: 1 cycle;
  - multiply: WIDTH + 1 cycles (1 cycle load, WIDTH iterate cycles).
- result and flags change only on the edge that sets out_valid; they stay stable while out_valid = 1 and out_ready = 0.
- in_ready is a function of registered state only (no combinational path from in_valid).
- out_valid does not depend on out_ready.

## Test plan
- Reset, then add with WIDTH=32, a=0x7FFFFFFF, b=1 -> out_valid 1 cycle after accept; result=0x80000000, ovf=1, neg=1, carry=0, zero=0.
- Sub with a=3, b=5 -> result=0xFFFFFFFE, carry=1, ovf=0, neg=1. Sub with a=b=0x1234 -> result=0, zero=1, carry=0.
- Logic ops with a=0x0000FFFF, b=0x00FF00FF:
  - and -> 0x000000FF;
  - or -> 0x00FFFFFF;
  - xor -> 0x00FFFF00;
  - not -> 0xFF00FF00.
- Shift: a=1, b=0x00000025 -> amount 5, result=0x20. Same a with b=31 -> 0x80000000, neg=1.
- Multiply:
  - a=0x10001, b=0x10001 -> after exactly 33 cycles result=0x00020001; busy=1 for 32 cycles; in_ready=0 throughout.
  - a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFE.
  - Repeat with WIDTH=8: a=15, b=17 -> result=0xFF, latency 9.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> result is stable and in_ready=0; pulse out_ready -> out_valid falls and in_ready rises the next cycle.
  - Assert rst at multiply cycle 10 -> next cycle IDLE, out_valid=0, result=0, and no output appears.
